move_cmd_queue: RTL
===================

// Module: move_cmd_queue
// PURPOSE
//   Consumes the single-cycle button-edge pulses from the button front end and
//   turns them into an ordered stream of 3-bit move commands for the Tetris game
//   engine. Commands pass through a small FIFO with a valid/ready handshake, so no
//   press is lost while the engine is busy on a drop or line-clear step.
//   Sits between the button front end and the piece-control FSM.
// PARAMETERS
//   DEPTH  4  FIFO entries; power of two, >=2
//   PTR_W  2  log2(DEPTH); count is PTR_W+1 bits
// PORTS
//   clk          in   1        system clock; all state updates on posedge
//   rst_n        in   1        asynchronous active-low reset
//   pulse_left   in   1        1-cycle pulse: move left
//   pulse_right  in   1        1-cycle pulse: move right
//   pulse_cw     in   1        1-cycle pulse: rotate clockwise
//   pulse_ccw    in   1        1-cycle pulse: rotate counter-clockwise
//   pulse_rst    in   1        1-cycle pulse: game reset request
//   cmd_ready    in   1        engine accepts head command this cycle
//   cmd_valid    out  1        head command present
//   cmd_code     out  3        0 NONE,1 LEFT,2 RIGHT,3 CW,4 CCW,5 RESET
//   cmd_count    out  PTR_W+1  entries held, 0..DEPTH
//   ovf          out  1        sticky: a command was dropped because FIFO full
//   coll         out  1        sticky: coincident pulses, lower priority dropped
//   flag_clr     in   1        clears ovf and coll next edge
// BEHAVIOUR
//   Reset (rst_n=0, async): ptrs=0, count=0, cmd_valid=0, cmd_code=0, ovf=0, coll=0.
//   Storage: circular buffer mem[DEPTH], wr_ptr/rd_ptr wrap DEPTH-1 -> 0.
//   Show-ahead: cmd_code = mem[rd_ptr] when count>0, else 0; cmd_valid = (count!=0).
//   Latency: pulse at edge N into empty FIFO -> cmd_valid=1 after edge N+1.
//   Select: at most one push/cycle; priority RESET > CW > CCW > LEFT > RIGHT.
//     Two or more movement/rotate pulses high in one cycle: push winner, set coll.
//   Pop: cmd_valid & cmd_ready -> rd_ptr++, count--.
//   Push: selected pulse & (count<DEPTH | pop this cycle) -> mem[wr_ptr]=code,
//     wr_ptr++, count++.
//   Full: push without pop when count==DEPTH -> command dropped, ovf=1, state unchanged.
//   Full + pop + push same cycle -> both happen, count stays DEPTH, ovf unchanged.
//   Empty + push + cmd_ready same cycle -> no pop (cmd_valid was 0), count becomes 1.
//   pulse_rst: flush regardless of other inputs or pending pop: rd_ptr=0,
//     wr_ptr=1, mem[0]=5, count=1. Other pulses that cycle are discarded,
//     coll set if any were high.
//   flag_clr: ovf/coll <= 0; a set event in the same cycle wins (flag stays 1).
//   No pulse, no pop: all state holds. Pulse inputs are assumed single-cycle;
//     a held level enqueues once per cycle (not filtered here).
//   Reset mid-operation: all entries discarded immediately; no partial command emitted.
// TESTING
//   1 pulse_cw at N, cmd_ready=0 -> from N+1: cmd_valid=1, cmd_code=3, cmd_count=1.
//   2 LEFT,RIGHT,CW,CCW,LEFT on 5 cycles, cmd_ready=0 -> count=4, ovf=1;
//     then ready=1 drains 1,2,3,4 in order, then cmd_valid=0, cmd_code=0.
//   3 pulse_left+pulse_cw same cycle -> one entry, code 3, coll=1;
//     flag_clr -> coll=0 next cycle.
//   4 FIFO full, cmd_ready=1 and pulse_ccw same cycle -> head popped, 4 at tail,
//     count stays 4, ovf stays 0.
//   5 3 entries queued, pulse_rst+pulse_right -> count=1, cmd_code=5, coll=1.
//   6 rst_n low mid-stream with 2 entries -> cmd_valid, count, flags 0 without a clock edge.

Source files
------------

// File: rtl/move_cmd_queue.sv
// move_cmd_queue: prioritised button pulses to a show-ahead FIFO of 3-bit move commands
module move_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_left,
  input  logic             pulse_right,
  input  logic             pulse_cw,
  input  logic             pulse_ccw,
  input  logic             pulse_rst,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic [PTR_W:0]   cmd_count,
  output logic             ovf,
  output logic             coll,
  input  logic             flag_clr
);
  logic [2:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [2:0] sel, n_mv;
  logic pop, push, full, ovf_ev, coll_ev;
  always_comb begin
    n_mv = 3'(pulse_left) + 3'(pulse_right) + 3'(pulse_cw) + 3'(pulse_ccw);
    sel = pulse_rst ? 3'd5 : pulse_cw ? 3'd3 : pulse_ccw ? 3'd4 : pulse_left ? 3'd1 : pulse_right ? 3'd2 : 3'd0;
    full = cmd_count == (PTR_W+1)'(DEPTH);
    pop = cmd_valid & cmd_ready;
    push = !pulse_rst && sel != 3'd0 && (!full || pop);
    ovf_ev = !pulse_rst && sel != 3'd0 && full && !pop;
    // a flush discards any other pulse, so any one of them counts as a collision
    coll_ev = pulse_rst ? n_mv != 3'd0 : n_mv > 3'd1;
  end
  assign cmd_valid = cmd_count != '0;
  assign cmd_code = cmd_valid ? mem[rd_ptr] : 3'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cmd_count <= '0;
      ovf <= 1'b0;
      coll <= 1'b0;
    end else begin
      if (pulse_rst) begin
        rd_ptr <= '0;
        wr_ptr <= PTR_W'(1);
        cmd_count <= (PTR_W+1)'(1);
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(push);
        cmd_count <= cmd_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
      ovf <= (ovf & ~flag_clr) | ovf_ev;
      coll <= (coll & ~flag_clr) | coll_ev;
    end
  end
  always_ff @(posedge clk) begin
    if (pulse_rst) mem[0] <= 3'd5;
    else if (push) mem[wr_ptr] <= sel;
  end
endmodule
